seg7_scan_ctrl: RTL

//  Time-multiplexed scan controller for an N-digit common-anode 7-seg display.

---
 rtl/seg7_scan_ctrl_pkg.sv | 6 +
 rtl/seg7_scan_ctrl_dec_7seg.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared display constants and slot-phase type (LEADING_ZERO_BLANK_EN selects leading-zero blanking in the top).
package seg7_scan_ctrl_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic AN_OFF = 1'b1;
  typedef enum logic {PH_DARK, PH_LIT} phase_t;
endpackage

// File: rtl/seg7_scan_ctrl_dec_7seg.sv
// dec_7seg: hex nibble to active-low segments, bit order g..a.
module dec_7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      default: o_seg = 7'h0E;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: frame-synchronous multiplexed 7-seg scanner with guarded slots.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the highest nonzero one.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIV         = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  pending,
  output logic                  frame_done
);
  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_shadow, r_stage;
  logic [N_DIGITS-1:0]   r_shadow_dp, r_stage_dp;
  logic                  w_pwrap, w_bnd, w_blank;
  phase_t                w_phase;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  always_comb begin
    w_pwrap = r_presc == PW'(DIV - 1);
    w_bnd   = enable && w_pwrap && r_idx == IW'(N_DIGITS - 1);
    w_phase = r_presc < PW'(BLANK_TICKS) ? PH_DARK : PH_LIT;
    w_nib   = r_shadow[4*r_idx +: 4];
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS:0] w_lz;
  // w_lz[i]: digit i and everything above it are zero; digit 0 stays visible
  always_comb begin
    w_lz = '0;
    w_lz[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--)
      w_lz[i] = w_lz[i+1] && r_shadow[4*i +: 4] == 4'h0;
    w_blank = w_lz[r_idx];
  end
`else
  always_comb w_blank = 1'b0;
`endif
  dec_7seg u_dec (.i_hex(w_nib), .o_seg(w_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_stage     <= '0;
      r_stage_dp  <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      seg_out     <= SEG_BLANK;
      dp_out      <= 1'b1;
      an_out      <= {N_DIGITS{AN_OFF}};
    end else begin
      if (enable) begin
        r_presc <= w_pwrap ? '0 : r_presc + 1'b1;
        if (w_pwrap) r_idx <= r_idx == IW'(N_DIGITS - 1) ? '0 : r_idx + 1'b1;
      end
      // a load on the boundary edge bypasses staging so stale staged data never shows
      if (w_bnd) begin
        pending <= 1'b0;
        if (load) begin
          r_shadow    <= data_in;
          r_shadow_dp <= dp_in;
        end else if (pending) begin
          r_shadow    <= r_stage;
          r_shadow_dp <= r_stage_dp;
        end
      end else if (load) begin
        r_stage    <= data_in;
        r_stage_dp <= dp_in;
        pending    <= 1'b1;
      end
      frame_done <= w_bnd;
      an_out     <= enable && w_phase == PH_LIT ? ~(N_DIGITS'(1) << r_idx) : {N_DIGITS{AN_OFF}};
      seg_out    <= w_blank ? SEG_BLANK : w_seg;
      dp_out     <= ~r_shadow_dp[r_idx];
    end
  end
endmodule
